// File: rtl/door_controller_if.sv
// Signal bundle between the door controller and the call buttons / motion controller.
// No valid/ready handshake here: every input is a level sampled on each rising clk edge, and every output is a registered level.
interface door_controller_if #(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = 2
);
    logic [FLOOR_W-1:0]    floor;
    logic                  at_rest;
    logic [NUM_FLOORS-1:0] call_req;
    logic                  obstruct;
    logic [NUM_FLOORS-1:0] call_led;
    logic                  door_open;
    logic                  door_busy;
    logic                  fault;
    logic [1:0]            state_dbg;

    modport master (
        output floor, at_rest, call_req, obstruct,
        input  call_led, door_open, door_busy, fault, state_dbg
    );

    modport slave (
        input  floor, at_rest, call_req, obstruct,
        output call_led, door_open, door_busy, fault, state_dbg
    );
endinterface

// File: rtl/door_controller.sv
// Elevator door controller: latches floor calls, opens at a pending floor while at rest,
// holds the door for OPEN_CYCLES (extended by obstruction or a repeat call), then closes.
module door_controller #(
    parameter int NUM_FLOORS  = 3,
    parameter int FLOOR_W     = 2,
    parameter int OPEN_CYCLES = 8
) (
    input logic             clk,
    input logic             rst,
    door_controller_if.slave bus
);
    localparam int TIMER_W = $clog2(OPEN_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(OPEN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [TIMER_W-1:0]    timer, timer_next;
    logic [NUM_FLOORS-1:0] call_led, call_led_next;
    logic                  fault;
    logic [NUM_FLOORS-1:0] floor_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] suppress_mask;
    logic                  call_here;
    logic                  pending_here;

    // An out-of-range floor yields an all-zero mask, so it can never open or be serviced.
    always_comb begin
        floor_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_mask[i] = (bus.floor == FLOOR_W'(i));
        end
    end

    assign call_here    = |(bus.call_req & floor_mask);
    assign pending_here = |(call_led & floor_mask);

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        clear_mask    = '0;
        suppress_mask = '0;
        case (state)
            IDLE: begin
                if (bus.at_rest && pending_here) begin
                    state_next = OPEN;
                    timer_next = RELOAD;
                    clear_mask = floor_mask;
                end
            end
            OPEN: begin
                suppress_mask = floor_mask;
                if (bus.obstruct || call_here) begin
                    timer_next = RELOAD;
                end else if (timer == '0) begin
                    state_next = CLOSING;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
            CLOSING: begin
                suppress_mask = floor_mask;
                if (bus.obstruct || call_here) begin
                    state_next = OPEN;
                    timer_next = RELOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        // Clear wins over a same-cycle set of the serviced floor.
        call_led_next = (call_led | (bus.call_req & ~suppress_mask)) & ~clear_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            call_led <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            call_led <= call_led_next;
            if (state != IDLE && !bus.at_rest) begin
                fault <= 1'b1;
            end
        end
    end

    assign bus.call_led  = call_led;
    assign bus.door_open = (state == OPEN);
    assign bus.door_busy = (state != IDLE);
    assign bus.fault     = fault;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_door_controller.sv
// Bench for door_controller: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a remaining-dwell reference model.
module tb_door_controller;
    localparam int NF = 3;
    localparam int FW = 2;
    localparam int OC = 8;
    localparam int W  = NF + 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [W-1:0] exp_q[$];

    door_controller_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dif ();

    door_controller #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .OPEN_CYCLES(OC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: mode 0 closed, 1 open, 2 closing; left = open cycles still to run.
    bit [NF-1:0] m_led;
    int          m_mode;
    int          m_left;
    bit          m_fault;

    task automatic model_step();
        bit [NF-1:0] req;
        bit [NF-1:0] nl;
        bit          in_rng;
        bit          here;
        if (rst) begin
            m_led   = '0;
            m_mode  = 0;
            m_left  = 0;
            m_fault = 1'b0;
        end else begin
            req    = dif.call_req;
            in_rng = (int'(dif.floor) < NF);
            here   = in_rng && req[dif.floor];
            if (m_mode == 0) begin
                nl = m_led | req;
                if (dif.at_rest && in_rng && m_led[dif.floor]) begin
                    nl[dif.floor] = 1'b0;
                    m_mode = 1;
                    m_left = OC;
                end
                m_led = nl;
            end else begin
                if (!dif.at_rest) m_fault = 1'b1;
                if (in_rng) req[dif.floor] = 1'b0;
                m_led = m_led | req;
                if (dif.obstruct || here) begin
                    m_mode = 1;
                    m_left = OC;
                end else if (m_mode == 2) begin
                    m_mode = 0;
                end else if (m_left == 1) begin
                    m_mode = 2;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            exp_q.push_back({m_led, (m_mode == 1), (m_mode != 0), m_fault});
        end
    end

    // scoreboard: one compare per cycle, away from the active edge
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("model{led,open,busy,fault}",
                    32'({dif.call_led, dif.door_open, dif.door_busy, dif.fault}), 32'(e));
            end
        end
    end

    task automatic pulse_call(input logic [NF-1:0] v);
        dif.call_req = v;
        step(1);
        dif.call_req = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst          = 1'b1;
        dif.floor    = '0;
        dif.at_rest  = 1'b1;
        dif.call_req = '1;
        dif.obstruct = 1'b0;
        step(2);
        rst          = 1'b0;
        dif.call_req = '0;
        chk("reset_led", 32'(dif.call_led), 32'd0);
        chk("reset_open", 32'(dif.door_open), 32'd0);
        chk("reset_busy", 32'(dif.door_busy), 32'd0);
        chk("reset_fault", 32'(dif.fault), 32'd0);

        // basic service at floor 1
        dif.floor = 2'd1;
        pulse_call(3'b010);
        chk("basic_led_p1", 32'(dif.call_led), 32'h2);
        chk("basic_open_p1", 32'(dif.door_open), 32'd0);
        step(1);
        chk("basic_open_p2", 32'(dif.door_open), 32'd1);
        chk("basic_led_p2", 32'(dif.call_led), 32'h0);
        step(7);
        chk("basic_open_p9", 32'(dif.door_open), 32'd1);
        step(1);
        chk("basic_open_p10", 32'(dif.door_open), 32'd0);
        chk("basic_busy_p10", 32'(dif.door_busy), 32'd1);
        step(1);
        chk("basic_busy_p11", 32'(dif.door_busy), 32'd0);

        // obstruction in dwell cycle 5 extends by a full dwell
        pulse_call(3'b010);
        step(5);
        dif.obstruct = 1'b1;
        step(1);
        dif.obstruct = 1'b0;
        step(7);
        chk("obst_open_p14", 32'(dif.door_open), 32'd1);
        step(1);
        chk("obst_open_p15", 32'(dif.door_open), 32'd0);
        step(1);
        chk("obst_busy_p16", 32'(dif.door_busy), 32'd0);

        // repeat call at the open floor behaves the same and does not latch
        pulse_call(3'b010);
        step(5);
        pulse_call(3'b010);
        chk("recall_led_p7", 32'(dif.call_led), 32'h0);
        step(7);
        chk("recall_open_p14", 32'(dif.door_open), 32'd1);
        step(1);
        chk("recall_open_p15", 32'(dif.door_open), 32'd0);
        step(1);

        // re-open from closing
        pulse_call(3'b010);
        step(9);
        chk("reopen_closing", 32'(dif.door_open), 32'd0);
        chk("reopen_busy", 32'(dif.door_busy), 32'd1);
        dif.obstruct = 1'b1;
        step(1);
        dif.obstruct = 1'b0;
        chk("reopen_p11", 32'(dif.door_open), 32'd1);
        step(7);
        chk("reopen_p18", 32'(dif.door_open), 32'd1);
        step(1);
        chk("reopen_p19", 32'(dif.door_open), 32'd0);
        step(1);

        // other-floor call while open at floor 0, then serve floor 2
        dif.floor = 2'd0;
        pulse_call(3'b001);
        step(2);
        pulse_call(3'b100);
        chk("other_led", 32'(dif.call_led), 32'h4);
        chk("other_open", 32'(dif.door_open), 32'd1);
        step(7);
        chk("other_idle", 32'(dif.door_busy), 32'd0);
        chk("other_led_held", 32'(dif.call_led), 32'h4);
        dif.floor = 2'd2;
        step(1);
        chk("floor2_open", 32'(dif.door_open), 32'd1);
        chk("floor2_led", 32'(dif.call_led), 32'h0);

        // fault is sticky; door keeps running
        chk("fault_before", 32'(dif.fault), 32'd0);
        dif.at_rest = 1'b0;
        step(1);
        dif.at_rest = 1'b1;
        chk("fault_set", 32'(dif.fault), 32'd1);
        step(10);
        chk("fault_sticky", 32'(dif.fault), 32'd1);
        chk("fault_closed", 32'(dif.door_busy), 32'd0);

        // out-of-range floor never opens; calls still latch
        dif.floor = 2'd3;
        pulse_call(3'b111);
        for (int i = 0; i < 20; i++) begin
            chk("oor_open", 32'(dif.door_open), 32'd0);
            step(1);
        end
        chk("oor_led", 32'(dif.call_led), 32'h7);

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rerst_fault", 32'(dif.fault), 32'd0);
        chk("rerst_led", 32'(dif.call_led), 32'h0);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) dif.floor = FW'($urandom_range(0, 3));
            dif.at_rest  = ($urandom_range(0, 31) != 0);
            dif.call_req = ($urandom_range(0, 7) == 0) ? NF'($urandom_range(0, 7)) : '0;
            dif.obstruct = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst          = 1'b0;
        dif.call_req = '0;
        dif.obstruct = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/door_controller.md
# door_controller

Parametrised elevator door controller for an N-floor car. It latches hall/car call requests per floor, opens the door when the car is at rest on a floor with a pending call, and holds it open for a programmable number of cycles. The hold is extended by obstruction or a repeat call, and the door can re-open during closing. It sits between the call buttons/LEDs and the motion controller, which must not move the car while `door_busy` is high.

## Interface
- `NUM_FLOORS`, default 3: number of served floors, ≥ 2.
- `FLOOR_W`, default 2: width of floor index, ≥ $clog2(NUM_FLOORS).
- `OPEN_CYCLES`, default 8: door-open dwell in clock cycles, ≥ 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `floor`  in  FLOOR_W  current car floor index from the motion controller.
- `at_rest`  in  1  car stopped and levelled at `floor`.
- `call_req`  in  NUM_FLOORS  one bit per floor, a high level in a cycle is a request.
- `obstruct`  in  1  door obstruction sensor, level.
- `call_led`  out  NUM_FLOORS  latched pending calls (drive button LEDs).
- `door_open`  out  1  door open command.
- `door_busy`  out  1  high in any state other than IDLE; motion controller must hold.
- `fault`  out  1  sticky: car left rest while door not closed.

## Operation
- States: IDLE, OPEN, CLOSING. `door_open` = (state == OPEN). `door_busy` = (state != IDLE).
- Call latch: `call_led[i]` is set on any cycle with `call_req[i]`=1. It is cleared only by service (below) or reset.
- IDLE → OPEN when `at_rest`=1, `floor` < NUM_FLOORS, and `call_led[floor]`=1 (registered value only).
  - On that edge: clear `call_led[floor]` and load timer = OPEN_CYCLES-1.
  - Set and clear of the same bit on the same edge: clear wins.
- OPEN:
  - `call_req[floor]`=1 reloads the timer to OPEN_CYCLES-1 and does not set `call_led[floor]`. Calls to other floors latch normally.
  - `obstruct`=1 reloads the timer to OPEN_CYCLES-1.
  - Otherwise the timer decrements by 1.
  - Timer==0 with no reload → CLOSING.
- CLOSING: lasts exactly one cycle.
  - `obstruct`=1 or `call_req[floor]`=1 → OPEN, timer reloaded, `call_led[floor]` not set.
  - Otherwise → IDLE.
- `floor` ≥ NUM_FLOORS: never opens; calls still latch.
- Fault: `at_rest`=0 in OPEN or CLOSING sets `fault`=1 (sticky until `rst`). The state machine continues normally; the door is not forced shut.
- Timer width: $clog2(OPEN_CYCLES)+1 bits, unsigned, never wraps (reload or exit at 0).

## Timing
- Reset values: state IDLE, timer 0, `call_led`=0, `door_open`=0, `door_busy`=0, `fault`=0. Reset overrides all inputs on the same edge, including mid-OPEN (door closes the next cycle, pending calls are lost).
- Call to LED latency: 1 cycle.
- Call at the current floor while IDLE and at rest:
  - `call_led` high 1 cycle after the request.
  - `door_open` high 2 cycles after the request.
  - `call_led[floor]` drops on the same edge `door_open` rises.
- Unextended dwell: `door_open` high for exactly OPEN_CYCLES cycles, then 1 CLOSING cycle with `door_busy`=1. `door_busy` falls OPEN_CYCLES+1 cycles after `door_open` rises.
- A reload in the last OPEN cycle (timer==0) keeps the state OPEN; `door_open` does not glitch.
- Re-open from CLOSING: `door_open` returns high on the next edge (one-cycle low gap).
- Back-to-back service: after returning to IDLE, a pending call at the new floor opens on the next edge if `at_rest` holds.

## Test plan
- Reset: assert `rst` 2 cycles with `call_req`=all ones → all outputs 0, `call_led`=0 after release.
- Basic service (OPEN_CYCLES=8): floor=1, `at_rest`=1, pulse `call_req`=3'b010 → `call_led`=010 at +1, `door_open` high from +2 to +9, `door_busy` low at +11, `call_led`=000.
- Extension: during OPEN, pulse `obstruct` at dwell cycle 5 → `door_open` stays high 8 further cycles. `call_req[floor]` at the same point gives the same result and `call_led` stays 000.
- Re-open: `obstruct`=1 in the CLOSING cycle → `door_open` low 1 cycle, then a full 8-cycle dwell.
- Other-floor call while open at floor 0: `call_req`=3'b100 → `call_led[2]`=1 and held after close. Move `floor` to 2 with `at_rest` → opens, `call_led[2]` clears.
- Fault/out-of-range: drop `at_rest` during OPEN → `fault`=1 and sticky. With `floor`=3 (NUM_FLOORS=3) and all calls pending → `door_open` never asserts.
